reload_counter: RTL and testbench

RELOAD_COUNTER -- requirements
Module: reload_counter

---
 rtl/reload_counter_pkg.sv | 35 +++
 rtl/reload_counter_rising_edge_detect.sv | 32 +++
 rtl/reload_counter.sv | 118 +++++++++++
 tb/tb_reload_counter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reload_counter_pkg.sv
// -----------------------------------------------------------------------------
// reload_counter_pkg
//   Shared types for the reload counter. It holds no configuration constants:
//   every tunable value is a module parameter on reload_counter.
//   - action_e      : the single update the counter performs on a clock edge
//   - decode_action : priority resolution of the per-edge update
// -----------------------------------------------------------------------------
package reload_counter_pkg;

    typedef enum logic [2:0] {
        ACT_HOLD,     // idle, nothing requested
        ACT_STOP,     // stop wins over everything else
        ACT_LAUNCH,   // idle -> running, count from 0
        ACT_RESTART,  // start rising edge while running (optional feature)
        ACT_TERMINAL, // value reached reload_value: pulse overflow, wrap to 0
        ACT_COUNT     // plain increment
    } action_e;

    // Priority: stop, then launch when idle, then restart, then terminal
    // count, then increment. A restart suppresses the terminal-count pulse.
    function automatic action_e decode_action(
        input logic stop,
        input logic running,
        input logic launch,
        input logic restart,
        input logic at_terminal
    );
        if (stop)        return ACT_STOP;
        if (!running)    return launch ? ACT_LAUNCH : ACT_HOLD;
        if (restart)     return ACT_RESTART;
        if (at_terminal) return ACT_TERMINAL;
        return ACT_COUNT;
    endfunction

endpackage

// File: rtl/reload_counter_rising_edge_detect.sv
// -----------------------------------------------------------------------------
// rising_edge_detect
//   Registers the previous sampled level of a signal and flags a rising edge:
//   the level is 1 on this edge and was 0 on the previous edge.
//   Ports:
//     clock   : rising-edge clock
//     reset   : asynchronous active-low reset, clears the level history
//     level_i : level being watched
//     rise_o  : combinational, 1 when level_i=1 and the previous sample was 0
// -----------------------------------------------------------------------------
module rising_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;
    logic level_d;

    assign level_d = level_i;
    assign rise_o  = level_i & ~level_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/reload_counter.sv
// -----------------------------------------------------------------------------
// reload_counter
//   Up-counter from 0 to reload_value with one-shot or auto-reload operation.
//   Parameters:
//     bitwidth                : width of the count and the reload value
//     start_resets_counting   : 1 -> a start rising edge while running restarts
//     enable_autoreload_input : 0 -> autoreload input ignored (treated as 0)
//     enable_autostart_input  : 0 -> autostart input ignored (treated as 0)
//   Ports:
//     clock        : rising-edge clock
//     reset        : asynchronous active-low reset
//     start        : level, launches counting when idle
//     stop         : level, halts counting and freezes value (highest priority)
//     autoreload   : level, keep running after terminal count
//     autostart    : level, acts as a held start while idle
//     reload_value : terminal count, sampled every cycle
//     value        : registered current count
//     running      : registered run flag
//     overflow     : registered one-cycle pulse on terminal count
// -----------------------------------------------------------------------------
module reload_counter
    import reload_counter_pkg::*;
#(
    parameter int unsigned bitwidth                = 8,
    parameter bit          start_resets_counting   = 1'b0,
    parameter bit          enable_autoreload_input = 1'b0,
    parameter bit          enable_autostart_input  = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                autoreload,
    input  logic                autostart,
    input  logic [bitwidth-1:0] reload_value,
    output logic [bitwidth-1:0] value,
    output logic                running,
    output logic                overflow
);

    localparam logic [bitwidth-1:0] ONE = {{(bitwidth-1){1'b0}}, 1'b1};

    logic [bitwidth-1:0] value_q, value_d;
    logic                running_q, running_d;
    logic                overflow_q, overflow_d;

    logic    start_rise;
    logic    eff_autoreload;
    logic    eff_autostart;
    action_e action;

    // History is tracked even when restart is disabled; the edge is then
    // simply masked off below.
    rising_edge_detect u_start_edge (
        .clock   (clock),
        .reset   (reset),
        .level_i (start),
        .rise_o  (start_rise)
    );

    assign eff_autoreload = enable_autoreload_input ? autoreload : 1'b0;
    assign eff_autostart  = enable_autostart_input  ? autostart  : 1'b0;

    assign action = decode_action(
        stop,
        running_q,
        start | eff_autostart,
        start_resets_counting & start_rise,
        (value_q == reload_value)
    );

    always_comb begin
        value_d    = value_q;
        running_d  = running_q;
        overflow_d = 1'b0;
        case (action)
            ACT_STOP: begin
                running_d = 1'b0;
            end
            ACT_LAUNCH: begin
                running_d = 1'b1;
                value_d   = '0;
            end
            ACT_RESTART: begin
                value_d = '0;
            end
            ACT_TERMINAL: begin
                value_d    = '0;
                overflow_d = 1'b1;
                running_d  = eff_autoreload;
            end
            ACT_COUNT: begin
                // Wraps naturally at 2^bitwidth when reload_value was lowered
                // below the current count.
                value_d = value_q + ONE;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q    <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            value_q    <= value_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
        end
    end

    assign value    = value_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_reload_counter.sv
// -----------------------------------------------------------------------------
// tb_reload_counter
//   Two counters share one stimulus stream: dut_a with default parameters and
//   dut_b with restart, autoreload and autostart all enabled. A behavioural
//   model per instance predicts the outputs after each rising edge; the
//   prediction is queued and a separate monitor compares it after the edge.
// -----------------------------------------------------------------------------
module tb_reload_counter;

    localparam int unsigned BW  = 8;
    localparam int unsigned MOD = 1 << BW;

    typedef struct {
        int unsigned v;
        bit          run;
        bit          ovf;
        bit          prev_start;
    } mstate_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          autoreload = 1'b0;
    logic          autostart = 1'b0;
    logic [BW-1:0] reload_value = 8'd12;

    logic [BW-1:0] value_a, value_b;
    logic          running_a, running_b;
    logic          overflow_a, overflow_b;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mstate_t ma, mb;
    logic [BW+1:0] qa[$];
    logic [BW+1:0] qb[$];

    always #5 clock = ~clock;

    reload_counter #(
        .bitwidth                (BW),
        .start_resets_counting   (1'b0),
        .enable_autoreload_input (1'b0),
        .enable_autostart_input  (1'b0)
    ) dut_a (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .autoreload   (autoreload),
        .autostart    (autostart),
        .reload_value (reload_value),
        .value        (value_a),
        .running      (running_a),
        .overflow     (overflow_a)
    );

    reload_counter #(
        .bitwidth                (BW),
        .start_resets_counting   (1'b1),
        .enable_autoreload_input (1'b1),
        .enable_autostart_input  (1'b1)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .autoreload   (autoreload),
        .autostart    (autostart),
        .reload_value (reload_value),
        .value        (value_b),
        .running      (running_b),
        .overflow     (overflow_b)
    );

    // Reference behaviour for one clock edge, written from the counter rules.
    function automatic mstate_t model_step(
        input mstate_t s, input bit restart_en, input bit ar_en, input bit as_en,
        input bit st, input bit sp, input bit ar, input bit as, input int unsigned rv
    );
        mstate_t n;
        bit go;
        bit rise;
        n            = s;
        n.ovf        = 1'b0;
        n.prev_start = st;
        go           = st || (as_en && as);
        rise         = st && !s.prev_start;
        if (sp) begin
            n.run = 1'b0;
        end else if (!s.run) begin
            if (go) begin
                n.run = 1'b1;
                n.v   = 0;
            end
        end else if (restart_en && rise) begin
            n.v = 0;
        end else if (s.v == rv) begin
            n.ovf = 1'b1;
            n.v   = 0;
            n.run = ar_en && ar;
        end else begin
            n.v = (s.v + 1) % MOD;
        end
        return n;
    endfunction

    function automatic logic [BW+1:0] pack_exp(input mstate_t s);
        return {s.v[BW-1:0], s.run, s.ovf};
    endfunction

    task automatic check(input string name, input logic [BW+1:0] act, input logic [BW+1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got value=%0d running=%0b overflow=%0b, expected value=%0d running=%0b overflow=%0b",
                     name, $time, act[BW+1:2], act[1], act[0], exp[BW+1:2], exp[1], exp[0]);
        end
    endtask

    // One clock cycle of stimulus: drive inputs away from the rising edge and
    // queue what each counter must show after that edge.
    task automatic cycle(input bit st, input bit sp, input bit ar, input bit as, input int unsigned rv);
        @(negedge clock);
        reset        = 1'b1;
        start        = st;
        stop         = sp;
        autoreload   = ar;
        autostart    = as;
        reload_value = rv[BW-1:0];
        ma = model_step(ma, 1'b0, 1'b0, 1'b0, st, sp, ar, as, rv);
        mb = model_step(mb, 1'b1, 1'b1, 1'b1, st, sp, ar, as, rv);
        qa.push_back(pack_exp(ma));
        qb.push_back(pack_exp(mb));
    endtask

    task automatic idle(input int unsigned n, input int unsigned rv);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, rv);
    endtask

    // Reset between edges; outputs must clear before the next rising edge.
    task automatic reset_pulse();
        @(negedge clock);
        #2;
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        check("async_reset_a", {value_a, running_a, overflow_a}, '0);
        check("async_reset_b", {value_b, running_b, overflow_b}, '0);
        ma = '{v: 0, run: 1'b0, ovf: 1'b0, prev_start: 1'b0};
        mb = '{v: 0, run: 1'b0, ovf: 1'b0, prev_start: 1'b0};
        qa.push_back(pack_exp(ma));
        qb.push_back(pack_exp(mb));
    endtask

    // Monitor: every edge with a pending prediction is compared just after it.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (qa.size() > 0) check("dut_a", {value_a, running_a, overflow_a}, qa.pop_front());
            if (qb.size() > 0) check("dut_b", {value_b, running_b, overflow_b}, qb.pop_front());
        end
    end

    initial begin
        bit st, sp, ar, as;
        int unsigned rv;

        ma = '{v: 0, run: 1'b0, ovf: 1'b0, prev_start: 1'b0};
        mb = '{v: 0, run: 1'b0, ovf: 1'b0, prev_start: 1'b0};

        repeat (3) @(posedge clock);
        #1;
        check("reset_state_a", {value_a, running_a, overflow_a}, '0);
        check("reset_state_b", {value_b, running_b, overflow_b}, '0);

        // No auto-resume after release.
        idle(3, 12);

        // Single-cycle start, full one-shot count to 12.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(16, 12);

        // Start held 7 cycles: same sequence, same alignment.
        for (int unsigned i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(10, 12);

        // Stop at value 5, then restart from 0.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(5, 12);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 12);
        idle(3, 12);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(15, 12);

        // Asynchronous reset while counting at 5.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(5, 12);
        reset_pulse();
        idle(4, 12);

        // Second start edge at value 4 (restarts only dut_b).
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(4, 12);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(16, 12);

        // Autostart + autoreload: continuous 13-cycle period on dut_b, then
        // both dropped so it stops after the next overflow.
        for (int unsigned i = 0; i < 40; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 12);
        idle(20, 12);

        // reload_value = 0: overflow every running edge.
        for (int unsigned i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 0);
        idle(4, 0);

        // reload_value dropped below the count: wrap through 2^BW.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 12);
        idle(8, 12);
        idle(260, 3);

        // Randomised traffic.
        rv = 12;
        ar = 1'b0;
        as = 1'b0;
        for (int unsigned i = 0; i < 3000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) ar = ~ar;
            if ($urandom_range(0, 15) == 0) as = ~as;
            if ($urandom_range(0, 63) == 0)
                rv = ($urandom_range(0, 7) == 0) ? $urandom_range(0, MOD - 1) : $urandom_range(0, 15);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            else cycle(st, sp, ar, as, rv);
        end

        repeat (3) @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
